// File: rtl/config_transmitter_if.sv
// config_transmitter_if: frame bus between the config transmitter and the configuration unit
interface config_transmitter_if;
    logic       request;
    logic       confirm;
    logic [7:0] key;
    logic [7:0] outData;
    modport master (output request, confirm, key, outData);
    modport slave  (input  request, confirm, key, outData);
endinterface

// File: rtl/config_transmitter.sv
// config_transmitter: sends an XOR-encrypted P/Q threshold pair as two request/confirm frames.
// Optional range checking of the thresholds is compiled in with CFG_TX_RANGE_CHECK_EN.
module config_transmitter #(
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                        clock,
    input  logic                        resetN,
    input  logic                        start,
    input  logic [6:0]                  valueP,
    input  logic [6:0]                  valueQ,
    input  logic [7:0]                  keyIn,
    config_transmitter_if.master        cfg,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);
    typedef enum logic [2:0] {IDLE, REQ_P, CONF_P, GAP, REQ_Q, CONF_Q, DONE} state_t;
    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [6:0] p_r, p_n, q_r, q_n;
    logic [7:0] k_r, k_n;
    logic       reject, err_n, p_frame, q_frame, req_n, conf_n, busy_n, done_n;
    logic [7:0] data_n, key_n;
`ifdef CFG_TX_RANGE_CHECK_EN
    assign reject = (valueP > 7'd100) || (valueQ > 7'd100) || (valueP > valueQ);
`else
    assign reject = 1'b0;
`endif
    // Next state, phase counter, latched operands, and the outputs that the next state will present
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        p_n     = p_r;
        q_n     = q_r;
        k_n     = k_r;
        err_n   = 1'b0;
        case (state)
            IDLE: if (start) begin
                if (reject) err_n = 1'b1;
                else begin
                    p_n     = valueP;
                    q_n     = valueQ;
                    k_n     = keyIn;
                    state_n = REQ_P;
                    cnt_n   = HOLD_LD;
                end
            end
            REQ_P: if (cnt == 8'd0) state_n = CONF_P; else cnt_n = cnt - 8'd1;
            CONF_P: if (GAP_CYCLES == 0) begin
                state_n = REQ_Q;
                cnt_n   = HOLD_LD;
            end else begin
                state_n = GAP;
                cnt_n   = GAP_LD;
            end
            GAP: if (cnt == 8'd0) begin
                state_n = REQ_Q;
                cnt_n   = HOLD_LD;
            end else cnt_n = cnt - 8'd1;
            REQ_Q: if (cnt == 8'd0) state_n = CONF_Q; else cnt_n = cnt - 8'd1;
            CONF_Q: state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        p_frame = (state_n == REQ_P) || (state_n == CONF_P);
        q_frame = (state_n == REQ_Q) || (state_n == CONF_Q);
        req_n   = p_frame || q_frame;
        conf_n  = (state_n == CONF_P) || (state_n == CONF_Q);
        busy_n  = req_n || (state_n == GAP);
        done_n  = state_n == DONE;
        data_n  = p_frame ? ({1'b0, p_n} ^ k_n) : q_frame ? ({1'b1, q_n} ^ k_n) : 8'd0;
        key_n   = busy_n ? k_n : 8'd0;
    end
    // State, counter, operand latches and registered outputs; reset clears everything at once
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            p_r         <= 7'd0;
            q_r         <= 7'd0;
            k_r         <= 8'd0;
            cfg.request <= 1'b0;
            cfg.confirm <= 1'b0;
            cfg.key     <= 8'd0;
            cfg.outData <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            p_r         <= p_n;
            q_r         <= q_n;
            k_r         <= k_n;
            cfg.request <= req_n;
            cfg.confirm <= conf_n;
            cfg.key     <= key_n;
            cfg.outData <= data_n;
            busy        <= busy_n;
            done        <= done_n;
            error       <= err_n;
        end
    end
endmodule

// File: tb/tb_config_transmitter.sv
// tb_config_transmitter: scoreboard bench for config_transmitter (default and HOLD=3/GAP=0 builds)
module tb_config_transmitter;
    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] data;
        logic [7:0] key;
    } ev_t;
    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [6:0] valueP = '0, valueQ = '0;
    logic [7:0] keyIn = '0;
    logic       busy0, done0, error0, busy1, done1, error1;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_err = 0;
    int         k;
    logic       prev_req [2] = '{1'b0, 1'b0};
    logic       prev_conf [2] = '{1'b0, 1'b0};
    ev_t        q0 [$];
    ev_t        q1 [$];
    config_transmitter_if if0 ();
    config_transmitter_if if1 ();
    config_transmitter dut0 (
        .clock(clock), .resetN(resetN), .start(start0), .valueP(valueP), .valueQ(valueQ),
        .keyIn(keyIn), .cfg(if0), .busy(busy0), .done(done0), .error(error0)
    );
    config_transmitter #(.HOLD_CYCLES(3), .GAP_CYCLES(0)) dut1 (
        .clock(clock), .resetN(resetN), .start(start1), .valueP(valueP), .valueQ(valueQ),
        .keyIn(keyIn), .cfg(if1), .busy(busy1), .done(done1), .error(error1)
    );
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    task automatic put(input int d, input int kind, input int c, input logic [7:0] data, input logic [7:0] kk);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = data;
        e.key  = kk;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
    endtask
    task automatic push_xfer(input int d, input int kk0, input logic [7:0] pb, input logic [7:0] qb, input logic [7:0] kk);
        int h = (d == 0) ? 1 : 3;
        int g = (d == 0) ? 2 : 0;
        put(d, 0, kk0 + 1, pb, kk);
        put(d, 1, kk0 + 1 + h, pb, kk);
        put(d, 0, kk0 + 2 + h + g, qb, kk);
        put(d, 1, kk0 + 2 + 2 * h + g, qb, kk);
        put(d, 2, kk0 + 3 + 2 * h + g, 8'd0, 8'd0);
    endtask
    task automatic ev(input int d, input int kind, input logic [7:0] data, input logic [7:0] kk, input logic bsy);
        ev_t e;
        logic ok;
        n_chk++;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            n_err++;
            $display("FAIL unexpected_event dut%0d kind=%0d cyc=%0d data=%h key=%h, required no event", d, kind, cyc, data, kk);
            return;
        end
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        ok = (e.kind == kind) && (e.cyc == cyc) &&
             ((kind >= 2) ? !bsy : (bsy && data == e.data && kk == e.key));
        if (!ok) begin
            n_err++;
            $display("FAIL event dut%0d got kind=%0d cyc=%0d data=%h key=%h busy=%b, required kind=%0d cyc=%0d data=%h key=%h busy=%b",
                     d, kind, cyc, data, kk, bsy, e.kind, e.cyc, e.data, e.key, e.kind < 2);
        end
    endtask
    task automatic mon(input int d, input logic req, input logic conf, input logic [7:0] data,
                       input logic [7:0] kk, input logic bsy, input logic dn, input logic er);
        if (req && (!prev_req[d] || prev_conf[d])) ev(d, 0, data, kk, bsy);
        if (conf) ev(d, 1, data, kk, bsy);
        if (dn) ev(d, 2, data, kk, bsy);
        if (er) ev(d, 3, data, kk, bsy);
        if (!bsy) begin
            n_chk++;
            if (req || conf || kk != 8'd0 || data != 8'd0) begin
                n_err++;
                $display("FAIL idle_outputs dut%0d cyc=%0d req=%b conf=%b key=%h data=%h, required all 0",
                         d, cyc, req, conf, kk, data);
            end
        end
        prev_req[d]  = req;
        prev_conf[d] = conf;
    endtask
    always @(negedge clock) mon(0, if0.request, if0.confirm, if0.outData, if0.key, busy0, done0, error0);
    always @(negedge clock) mon(1, if1.request, if1.confirm, if1.outData, if1.key, busy1, done1, error1);
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask
    task automatic go(input int d, input logic [6:0] p, input logic [6:0] q, input logic [7:0] kk);
        valueP = p;
        valueQ = q;
        keyIn  = kk;
        if (d == 0) start0 = 1'b1; else start1 = 1'b1;
        wait_cyc(1);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask
    task automatic check_zero(input string name, input int d);
        logic [7:0] data = d == 0 ? if0.outData : if1.outData;
        logic [7:0] kk   = d == 0 ? if0.key : if1.key;
        logic [4:0] bits = d == 0 ? {if0.request, if0.confirm, busy0, done0, error0}
                                  : {if1.request, if1.confirm, busy1, done1, error1};
        n_chk++;
        if (data != 8'd0 || kk != 8'd0 || bits != 5'd0) begin
            n_err++;
            $display("FAIL %s dut%0d data=%h key=%h req/conf/busy/done/err=%b, required all 0", name, d, data, kk, bits);
        end
    endtask
    initial begin
        wait_cyc(3);
        check_zero("reset_state", 0);
        check_zero("reset_state", 1);
        resetN = 1'b1;
        wait_cyc(2);
        // basic transfer; inputs disturbed after acceptance must not matter
        k = cyc;
        push_xfer(0, k, 8'h99, 8'h41, 8'hA5);
        go(0, 7'd60, 7'd100, 8'hA5);
        valueP = 7'h11;
        valueQ = 7'h22;
        keyIn  = 8'hFF;
        wait_cyc(10);
        // zero key, extreme values
        k = cyc;
        push_xfer(0, k, 8'h7F, 8'h80, 8'h00);
        go(0, 7'h7F, 7'h00, 8'h00);
        wait_cyc(10);
        // start held high across the whole transfer and into IDLE
        k = cyc;
        push_xfer(0, k, 8'h11, 8'h92, 8'h10);
        push_xfer(0, k + 8, 8'h11, 8'h92, 8'h10);
        valueP = 7'd1;
        valueQ = 7'd2;
        keyIn  = 8'h10;
        start0 = 1'b1;
        wait_cyc(9);
        start0 = 1'b0;
        wait_cyc(10);
        // reset during GAP: only the P frame may ever appear
        k = cyc;
        put(0, 0, k + 1, 8'h39, 8'h3C);
        put(0, 1, k + 2, 8'h39, 8'h3C);
        go(0, 7'd5, 7'd6, 8'h3C);
        wait_cyc(2);
        resetN = 1'b0;
        #1;
        check_zero("async_reset", 0);
        wait_cyc(2);
        resetN = 1'b1;
        wait_cyc(15);
        // long hold, no gap
        k = cyc;
        push_xfer(1, k, 8'h5F, 8'hC1, 8'h55);
        go(1, 7'd10, 7'd20, 8'h55);
        wait_cyc(12);
        // out-of-range thresholds
        k = cyc;
`ifdef CFG_TX_RANGE_CHECK_EN
        put(0, 3, k + 1, 8'h00, 8'h00);
`else
        push_xfer(0, k, 8'h6A, 8'hBD, 8'h0F);
`endif
        go(0, 7'd101, 7'd50, 8'h0F);
        wait_cyc(12);
        n_chk++;
        if (q0.size() + q1.size() != 0) begin
            n_err++;
            $display("FAIL missing_events pending=%0d, required 0", q0.size() + q1.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
